mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one pipelined, multi-cycle unified memory between the I-cache fill path and the D-cache (fill plus write-through).
- Sits between both cache controllers and the unified memory model. Cache controllers stall the pipeline while their request is held.
- Sequences 8-word block fills: issues consecutive read addresses, counts the returning words, steers them to the owning cache, then signals completion.

Parameters:
ADDR_W, 16, byte-address width
DATA_W, 16, memory word width
WORDS, 8, words per cache block (16-byte block); counter width CNT_W = log2(WORDS)

Ports:
clk  in  1  system clock
rst_n  in  1  reset
i_miss  in  1  I-cache fill request, held until i_fill_done
i_miss_addr  in  ADDR_W  I-cache miss byte address
i_fill_we  out  1  write returned word into I-cache
i_fill_word  out  CNT_W  word index within block
i_fill_data  out  DATA_W  returned word
i_fill_done  out  1  one-cycle pulse, I fill complete
d_miss  in  1  D-cache fill request, held until d_fill_done
d_miss_addr  in  ADDR_W  D-cache miss byte address
d_fill_we  out  1  write returned word into D-cache
d_fill_word  out  CNT_W  word index within block
d_fill_data  out  DATA_W  returned word
d_fill_done  out  1  one-cycle pulse, D fill complete
d_wr  in  1  write-through request, held until d_wr_ack
d_wr_addr  in  ADDR_W  write byte address
d_wr_data  in  DATA_W  write data
d_wr_ack  out  1  one-cycle pulse, write issued
mem_en  out  1  memory access enable
mem_wr  out  1  memory write
mem_addr  out  ADDR_W  memory byte address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data
mem_rvalid  in  1  mem_rdata valid this cycle
busy  out  1  state != IDLE

Behaviour:
- Clock and reset: single clock, clk; reset rst_n is asynchronous, active-low.
- On reset:
  - state=IDLE, issue_cnt=0, ret_cnt=0, latched block address=0.
  - All outputs 0 (fill_data outputs follow mem_rdata; their fill_we is 0).
- States: IDLE, WRITE, FILL_I, FILL_D.
- IDLE arbitration, fixed priority d_wr > d_miss > i_miss:
  - Winning request's address (and data, for writes) latched on the sampling edge.
  - Next cycle enters WRITE / FILL_D / FILL_I respectively.
  - No preemption once granted.
- WRITE (exactly 1 cycle):
  - mem_en=1, mem_wr=1, mem_addr={addr[15:1],0}, mem_wdata=latched data, d_wr_ack=1.
  - Next state IDLE.
- FILL_x issue phase:
  - While issue_cnt<WORDS: mem_en=1, mem_wr=0, mem_addr={blk[15:4], issue_cnt, 1'b0}.
  - issue_cnt increments every cycle; 8 reads go out on consecutive cycles.
  - After the 8th issue, mem_en=0.
- FILL_x return phase:
  - Each cycle with mem_rvalid=1: x_fill_we=1, x_fill_word=ret_cnt, then ret_cnt++.
  - Returns may overlap the issue phase.
  - On the return with ret_cnt==WORDS-1: x_fill_done=1 in the same cycle as the last x_fill_we. Counters clear; next state IDLE.
- Latency: request seen in IDLE at cycle 0 → first read issued in cycle 1. With memory latency L, done is asserted in cycle 8+L. A new grant is possible in cycle 9+L at the earliest.
- Outputs are Moore-decoded from state and counters, except fill_we/fill_done, which are qualified by mem_rvalid.
- Boundary conditions:
  - mem_rvalid in IDLE or WRITE: ignored, no fill_we.
  - Request deasserted mid-fill (e.g. flush): the fill still completes and all 8 words are written. The requester may discard them.
  - Simultaneous d_miss and i_miss: D is served first. I stays pending and is granted in the first IDLE cycle after d_fill_done, provided no d_wr or d_miss is present then.
  - Asynchronous reset mid-fill: immediate return to IDLE. In-flight mem_rvalid after reset is ignored.
  - Wrap-around: a block at 0xFFF0 issues 0xFFF0..0xFFFE with no carry into other blocks.
  - ret_cnt never exceeds WORDS-1. A 9th valid in one fill cannot occur because state is already IDLE.

Decomposition:
- Package mem_arb_pkg:
  - state enum {IDLE, WRITE, FILL_I, FILL_D}
  - WORDS, CNT_W, BLK_OFF_W = 4 constants
- Sub-module blk_counter: CNT_W-bit up-counter with clear, increment and terminal-count flag. Instantiated twice (issue_cnt, ret_cnt).

Test Plan:
- Lone i_miss at 0x1234, memory L=4:
  - mem_addr 0x1230,0x1232..0x123E in cycles 1..8.
  - i_fill_we cycles 5..12 with words 0..7.
  - i_fill_done in cycle 12 only; d_* outputs stay 0.
- d_miss and i_miss both raised in the same cycle:
  - D block is filled first with d_fill_done.
  - I reads begin one cycle after the IDLE cycle following d_fill_done.
- d_wr at 0x0041 with data 0xBEEF:
  - Next cycle mem_en=1, mem_wr=1, mem_addr=0x0040, mem_wdata=0xBEEF, d_wr_ack=1.
  - Back to IDLE after 1 cycle.
- d_wr and d_miss raised together: write is acked first, then the D fill runs.
- rst_n pulsed low mid-fill after 3 returns:
  - All outputs go to 0 immediately.
  - Later stray mem_rvalid pulses produce no fill_we.
  - A new i_miss then fills correctly from word 0.
- Fill at 0xFFF8: addresses 0xFFF0..0xFFFE; no access outside that block.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared constants and state encoding for the unified-memory arbiter.
package mem_arb_pkg;

  localparam int unsigned WORDS     = 8;
  localparam int unsigned CNT_W     = $clog2(WORDS);
  localparam int unsigned BLK_OFF_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    FILL_I = 2'd2,
    FILL_D = 2'd3
  } state_t;

endpackage

// File: rtl/blk_counter.sv
// Word counter within a cache block: clear has priority over increment,
// terminal count flags the last word of the block.
module blk_counter #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == '1);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the unified memory between I-cache fills, D-cache fills and
// D-cache write-through, sequencing 8-word block fills.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_miss,
  input  logic [ADDR_W-1:0] i_miss_addr,
  output logic              i_fill_we,
  output logic [CNT_W-1:0]  i_fill_word,
  output logic [DATA_W-1:0] i_fill_data,
  output logic              i_fill_done,
  input  logic              d_miss,
  input  logic [ADDR_W-1:0] d_miss_addr,
  output logic              d_fill_we,
  output logic [CNT_W-1:0]  d_fill_word,
  output logic [DATA_W-1:0] d_fill_data,
  output logic              d_fill_done,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_wr_addr,
  input  logic [DATA_W-1:0] d_wr_data,
  output logic              d_wr_ack,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic              busy
);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                issue_done_q, issue_done_d;

  logic [CNT_W-1:0]    issue_cnt, ret_cnt;
  logic                issue_tc, ret_tc;
  logic                filling, issuing, ret_inc, fill_last;

  assign filling   = (state_q == FILL_I) || (state_q == FILL_D);
  assign issuing   = filling && !issue_done_q;
  assign ret_inc   = filling && mem_rvalid;
  assign fill_last = ret_inc && ret_tc;

  // The 3-bit issue counter wraps after the 8th read; issue_done_q marks that.
  blk_counter #(.W(CNT_W)) u_issue_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (fill_last),
    .inc_i (issuing),
    .cnt_o (issue_cnt),
    .tc_o  (issue_tc)
  );

  blk_counter #(.W(CNT_W)) u_ret_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (fill_last),
    .inc_i (ret_inc),
    .cnt_o (ret_cnt),
    .tc_o  (ret_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      data_q       <= '0;
      issue_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      issue_done_q <= issue_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    data_d       = data_q;
    issue_done_d = issue_done_q;
    case (state_q)
      IDLE: begin
        if (d_wr) begin
          state_d = WRITE;
          addr_d  = d_wr_addr;
          data_d  = d_wr_data;
        end else if (d_miss) begin
          state_d = FILL_D;
          addr_d  = d_miss_addr;
        end else if (i_miss) begin
          state_d = FILL_I;
          addr_d  = i_miss_addr;
        end
      end
      WRITE: state_d = IDLE;
      FILL_I, FILL_D: begin
        if (issuing && issue_tc) begin
          issue_done_d = 1'b1;
        end
        if (fill_last) begin
          state_d      = IDLE;
          issue_done_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_en      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    d_wr_ack    = 1'b0;
    i_fill_we   = 1'b0;
    i_fill_word = '0;
    i_fill_done = 1'b0;
    d_fill_we   = 1'b0;
    d_fill_word = '0;
    d_fill_done = 1'b0;
    case (state_q)
      WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = {addr_q[ADDR_W-1:1], 1'b0};
        mem_wdata = data_q;
        d_wr_ack  = 1'b1;
      end
      FILL_I, FILL_D: begin
        if (issuing) begin
          mem_en   = 1'b1;
          mem_addr = {addr_q[ADDR_W-1:BLK_OFF_W], issue_cnt, 1'b0};
        end
        if (state_q == FILL_I) begin
          i_fill_we   = mem_rvalid;
          i_fill_word = ret_cnt;
          i_fill_done = fill_last;
        end else begin
          d_fill_we   = mem_rvalid;
          d_fill_word = ret_cnt;
          d_fill_done = fill_last;
        end
      end
      default: ;
    endcase
  end

  assign i_fill_data = mem_rdata;
  assign d_fill_data = mem_rdata;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: pipelined memory environment,
// transaction-level reference model, directed vectors and random traffic.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_miss, d_miss, d_wr;
  logic [15:0] i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data;
  logic        i_fill_we, i_fill_done, d_fill_we, d_fill_done, d_wr_ack;
  logic [2:0]  i_fill_word, d_fill_word;
  logic [15:0] i_fill_data, d_fill_data;
  logic        mem_en, mem_wr, mem_rvalid, busy;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_miss(i_miss), .i_miss_addr(i_miss_addr),
    .i_fill_we(i_fill_we), .i_fill_word(i_fill_word), .i_fill_data(i_fill_data),
    .i_fill_done(i_fill_done),
    .d_miss(d_miss), .d_miss_addr(d_miss_addr),
    .d_fill_we(d_fill_we), .d_fill_word(d_fill_word), .d_fill_data(d_fill_data),
    .d_fill_done(d_fill_done),
    .d_wr(d_wr), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data), .d_wr_ack(d_wr_ack),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .busy(busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Memory environment: fixed-latency read pipeline plus sparse storage.
  logic [15:0] mem_arr [logic [15:0]];
  bit          pipe_v [16];
  logic [15:0] pipe_a [16];
  int unsigned lat = 4;
  int          cyc = 0;
  bit          stray_en = 0;

  function automatic logic [15:0] mem_read(input logic [15:0] a);
    if (mem_arr.exists(a)) return mem_arr[a];
    return (a ^ 16'h5A5A) + 16'h0103;
  endfunction

  function automatic int pending();
    int n = 0;
    for (int k = 0; k < 16; k++) if (pipe_v[k]) n++;
    return n;
  endfunction

  // Reference model: current transaction kind and word counts.
  int          m_kind;  // 0 none, 1 write, 2 I fill, 3 D fill
  logic [15:0] m_addr, m_data;
  int          m_iss, m_ret;

  task automatic model_reset();
    m_kind = 0; m_iss = 0; m_ret = 0; m_addr = '0; m_data = '0;
  endtask

  task automatic model_update();
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (m_kind == 0) begin
      m_iss = 0; m_ret = 0;
      if (d_wr) begin
        m_kind = 1; m_addr = d_wr_addr; m_data = d_wr_data;
      end else if (d_miss) begin
        m_kind = 3; m_addr = d_miss_addr;
      end else if (i_miss) begin
        m_kind = 2; m_addr = i_miss_addr;
      end
    end else if (m_kind == 1) begin
      m_kind = 0;
    end else begin
      if (m_iss < 8) m_iss++;
      if (mem_rvalid) m_ret++;
      if (m_ret == 8) m_kind = 0;
    end
  endtask

  task automatic compare();
    bit          e_en, e_iwe, e_dwe;
    logic [15:0] e_addr, e_word_addr;
    e_en        = (m_kind == 1) || (m_kind >= 2 && m_iss < 8);
    e_iwe       = (m_kind == 2) && mem_rvalid;
    e_dwe       = (m_kind == 3) && mem_rvalid;
    e_addr      = (m_kind == 1) ? (m_addr & 16'hFFFE) : ((m_addr & 16'hFFF0) + 16'(2 * m_iss));
    e_word_addr = (m_addr & 16'hFFF0) + 16'(2 * m_ret);
    chk("busy", busy, m_kind != 0);
    chk("mem_en", mem_en, e_en);
    chk("d_wr_ack", d_wr_ack, m_kind == 1);
    chk("i_fill_we", i_fill_we, e_iwe);
    chk("d_fill_we", d_fill_we, e_dwe);
    chk("i_fill_done", i_fill_done, e_iwe && m_ret == 7);
    chk("d_fill_done", d_fill_done, e_dwe && m_ret == 7);
    if (e_en) begin
      chk("mem_wr", mem_wr, m_kind == 1);
      chk("mem_addr", mem_addr, e_addr);
      if (m_kind == 1) chk("mem_wdata", mem_wdata, m_data);
    end
    if (e_iwe) begin
      chk("i_fill_word", i_fill_word, m_ret);
      chk("i_fill_data", i_fill_data, mem_read(e_word_addr));
    end
    if (e_dwe) begin
      chk("d_fill_word", d_fill_word, m_ret);
      chk("d_fill_data", d_fill_data, mem_read(e_word_addr));
    end
  endtask

  // Per-cycle log relative to base, for the directed sequences.
  int          base = -1000;
  bit          lg_en[64], lg_wr[64], lg_ack[64], lg_busy[64];
  bit          lg_iwe[64], lg_idone[64], lg_dwe[64], lg_ddone[64], lg_dany[64];
  logic [15:0] lg_addr[64], lg_wdata[64];
  int          lg_iword[64];
  bit          last_idone, last_ddone;
  int          cnt_iwe = 0;

  task automatic cycle();
    int slot, idx;
    slot = cyc % 16;
    if (!rst_n) model_reset();
    if (pipe_v[slot]) begin
      mem_rvalid = 1'b1; mem_rdata = mem_read(pipe_a[slot]); pipe_v[slot] = 0;
    end else if (stray_en && pending() == 0 && m_kind < 2 && $urandom_range(0, 7) == 0) begin
      mem_rvalid = 1'b1; mem_rdata = 16'($urandom);
    end else begin
      mem_rvalid = 1'b0; mem_rdata = 16'($urandom);
    end
    #1;
    compare();
    idx = cyc - base;
    if (idx >= 0 && idx < 64) begin
      lg_en[idx] = mem_en; lg_wr[idx] = mem_wr; lg_ack[idx] = d_wr_ack; lg_busy[idx] = busy;
      lg_addr[idx] = mem_addr; lg_wdata[idx] = mem_wdata;
      lg_iwe[idx] = i_fill_we; lg_idone[idx] = i_fill_done; lg_iword[idx] = int'(i_fill_word);
      lg_dwe[idx] = d_fill_we; lg_ddone[idx] = d_fill_done;
      lg_dany[idx] = d_fill_we | d_fill_done | (d_fill_word != 0);
    end
    last_idone = i_fill_done;
    last_ddone = d_fill_done;
    if (i_fill_we) cnt_iwe++;
    if (mem_en && rst_n) begin
      if (mem_wr) mem_arr[mem_addr] = mem_wdata;
      else begin
        pipe_v[(cyc + int'(lat)) % 16] = 1;
        pipe_a[(cyc + int'(lat)) % 16] = mem_addr;
      end
    end
    if (i_fill_done) i_miss = 1'b0;
    if (d_fill_done) d_miss = 1'b0;
    if (d_wr_ack) d_wr = 1'b0;
    model_update();
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_done(input bit is_i, input int budget, input string nm);
    int n = 0;
    bit seen = 0;
    while (!seen && n < budget) begin
      cycle();
      n++;
      seen = is_i ? last_idone : last_ddone;
    end
    chk(nm, seen, 1'b1);
    cycle();
    cycle();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    i_miss = 0; d_miss = 0; d_wr = 0;
    cycle();
    while ((m_kind != 0 || pending() != 0) && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_busy", busy, 1'b0);
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    logic [15:0] exp_addr;
    logic [15:0] exp_wdata;
  } wvec_t;

  wvec_t wt[4];
  int    first, nwe, c0, kr;

  initial begin
    wt[0] = '{16'h0041, 16'hBEEF, 16'h0040, 16'hBEEF};
    wt[1] = '{16'hFFFF, 16'h1234, 16'hFFFE, 16'h1234};
    wt[2] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
    wt[3] = '{16'h8002, 16'hA5A5, 16'h8002, 16'hA5A5};

    rst_n = 1'b0;
    i_miss = 0; d_miss = 0; d_wr = 0;
    i_miss_addr = '0; d_miss_addr = '0; d_wr_addr = '0; d_wr_data = '0;
    mem_rvalid = 0; mem_rdata = '0;
    for (int k = 0; k < 16; k++) pipe_v[k] = 0;
    model_reset();
    @(negedge clk);
    mem_rvalid = 1'b1;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_mem_wr", mem_wr, 1'b0);
    chk("rst_mem_addr", mem_addr, 16'h0);
    chk("rst_mem_wdata", mem_wdata, 16'h0);
    chk("rst_ack", d_wr_ack, 1'b0);
    chk("rst_i_we", i_fill_we, 1'b0);
    chk("rst_i_word", i_fill_word, 3'd0);
    chk("rst_d_we", d_fill_we, 1'b0);
    chk("rst_d_word", d_fill_word, 3'd0);
    chk("rst_done", {i_fill_done, d_fill_done}, 2'b00);
    mem_rvalid = 1'b0;
    @(negedge clk);
    cyc++;
    rst_n = 1'b1;
    cycle();

    // Lone I miss, latency 4.
    lat = 4;
    drain(40);
    base = cyc; i_miss = 1; i_miss_addr = 16'h1234;
    wait_done(1, 40, "i_done_seen");
    for (int k = 0; k < 15; k++) begin
      chk("i_en", lg_en[k], k >= 1 && k <= 8);
      if (k >= 1 && k <= 8) chk("i_addr", lg_addr[k], 16'h1230 + 16'(2 * (k - 1)));
      chk("i_we", lg_iwe[k], k >= 5 && k <= 12);
      if (k >= 5 && k <= 12) chk("i_word", lg_iword[k], k - 5);
      chk("i_done_cyc", lg_idone[k], k == 12);
      chk("d_quiet", lg_dany[k], 1'b0);
    end

    // Simultaneous D and I misses.
    drain(40);
    base = cyc; d_miss = 1; d_miss_addr = 16'h2006; i_miss = 1; i_miss_addr = 16'h300A;
    wait_done(1, 60, "di_i_done_seen");
    chk("di_d_done", lg_ddone[12], 1'b1);
    chk("di_idle_gap", lg_busy[13], 1'b0);
    chk("di_i_first_en", lg_en[14], 1'b1);
    chk("di_i_first_addr", lg_addr[14], 16'h3000);
    first = -1;
    for (int k = 0; k < 40; k++) if (lg_iwe[k] && first < 0) first = k;
    chk("di_i_first_we", first, 18);
    chk("di_i_done", lg_idone[25], 1'b1);

    // Write-through vectors.
    for (int v = 0; v < 4; v++) begin
      drain(40);
      base = cyc; d_wr = 1; d_wr_addr = wt[v].addr; d_wr_data = wt[v].data;
      cycle(); cycle(); cycle();
      chk("wr_ack0", lg_ack[0], 1'b0);
      chk("wr_ack", lg_ack[1], 1'b1);
      chk("wr_en", lg_en[1], 1'b1);
      chk("wr_wr", lg_wr[1], 1'b1);
      chk("wr_addr", lg_addr[1], wt[v].exp_addr);
      chk("wr_wdata", lg_wdata[1], wt[v].exp_wdata);
      chk("wr_idle", lg_busy[2], 1'b0);
      chk("wr_ack2", lg_ack[2], 1'b0);
    end

    // Write and D miss together.
    drain(40);
    base = cyc; d_wr = 1; d_wr_addr = 16'h0100; d_wr_data = 16'h1111;
    d_miss = 1; d_miss_addr = 16'h0150;
    wait_done(0, 40, "wd_d_done_seen");
    chk("wd_ack", lg_ack[1], 1'b1);
    chk("wd_idle", lg_busy[2], 1'b0);
    chk("wd_fill_en", lg_en[3], 1'b1);
    chk("wd_fill_addr", lg_addr[3], 16'h0150);
    chk("wd_d_done", lg_ddone[14], 1'b1);

    // Asynchronous reset after three returned words.
    drain(40);
    base = cyc; i_miss = 1; i_miss_addr = 16'h4000;
    c0 = cnt_iwe;
    for (int n = 0; n < 30 && cnt_iwe - c0 < 3; n++) cycle();
    chk("rs_three", cnt_iwe - c0, 3);
    kr = cyc - base;
    rst_n = 1'b0; i_miss = 0;
    cycle();
    chk("rs_busy", lg_busy[kr], 1'b0);
    chk("rs_en", lg_en[kr], 1'b0);
    chk("rs_we", lg_iwe[kr], 1'b0);
    cycle();
    rst_n = 1'b1;
    c0 = cnt_iwe;
    stray_en = 1;
    for (int n = 0; n < 12; n++) cycle();
    stray_en = 0;
    chk("rs_stray_we", cnt_iwe - c0, 0);
    drain(40);
    base = cyc; i_miss = 1; i_miss_addr = 16'h4008;
    wait_done(1, 40, "rs_refill_done");
    first = -1; nwe = 0;
    for (int k = 0; k < 20; k++) if (lg_iwe[k]) begin
      if (first < 0) first = k;
      nwe++;
    end
    chk("rs_refill_cnt", nwe, 8);
    if (first >= 0) chk("rs_refill_w0", lg_iword[first], 0);

    // Top-of-memory block, latency 3.
    drain(40);
    lat = 3;
    base = cyc; d_miss = 1; d_miss_addr = 16'hFFF8;
    wait_done(0, 40, "wrap_done_seen");
    for (int k = 1; k <= 8; k++) chk("wrap_addr", lg_addr[k], 16'hFFF0 + 16'(2 * (k - 1)));
    for (int k = 0; k < 16; k++) if (lg_en[k]) chk("wrap_blk", lg_addr[k] & 16'hFFF0, 16'hFFF0);
    chk("wrap_done", lg_ddone[11], 1'b1);

    // Random traffic with flushes and stray valids.
    drain(40);
    lat = $urandom_range(1, 6);
    base = -100000;
    stray_en = 1;
    for (int n = 0; n < 3000; n++) begin
      if (!d_wr && $urandom_range(0, 9) == 0) begin
        d_wr = 1;
        d_wr_addr = ($urandom_range(0, 3) == 0) ? (16'hFFF0 | 16'($urandom_range(0, 15))) : 16'($urandom);
        d_wr_data = 16'($urandom);
      end
      if (!d_miss && $urandom_range(0, 7) == 0) begin
        d_miss = 1;
        d_miss_addr = ($urandom_range(0, 3) == 0) ? (16'hFFF0 | 16'($urandom_range(0, 15))) : 16'($urandom);
      end else if (d_miss && $urandom_range(0, 99) == 0) d_miss = 0;
      if (!i_miss && $urandom_range(0, 7) == 0) begin
        i_miss = 1;
        i_miss_addr = 16'($urandom);
      end else if (i_miss && $urandom_range(0, 99) == 0) i_miss = 0;
      cycle();
    end
    stray_en = 0;
    drain(100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
